// File: rtl/count_led_driver_if.sv
// Method-call channel between count_led_driver and the counter core's count_value method.
// The master side raises EN; the slave side presents the return value and RDY.
interface count_led_driver_if #(
  parameter int unsigned NLED = 4
);
  logic            count_value_en;
  logic [NLED-1:0] count_value_rv;
  logic            count_value_rdy;

  modport master (
    output count_value_en,
    input  count_value_rv,
    input  count_value_rdy
  );

  modport slave (
    input  count_value_en,
    output count_value_rv,
    output count_value_rdy
  );
endinterface

// File: rtl/count_led_driver.sv
// Polls the counter core's count_value method once per tick, latches the result and drives
// one PWM-faded LED per count bit plus a heartbeat and a sticky stall flag.
module count_led_driver #(
  parameter int unsigned NLED          = 4,
  parameter int unsigned TICK_DIV      = 2097152,
  parameter int unsigned PWM_W         = 8,
  parameter int unsigned FADE_DIV      = 4096,
  parameter int unsigned STEP          = 1,
  parameter int unsigned TIMEOUT_TICKS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  count_led_driver_if.master  cv_if,
  output logic                tick_o,
  output logic [NLED-1:0]     led_o,
  output logic                led_hb_o,
  output logic                stall_o
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FadeW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int unsigned MissW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [FadeW-1:0] FadeLast  = FadeW'(FADE_DIV - 1);
  localparam logic [MissW-1:0] MissMax   = MissW'(TIMEOUT_TICKS);
  localparam logic [MissW-1:0] MissLast  = MissW'(TIMEOUT_TICKS - 1);
  localparam logic [PWM_W-1:0] BrightMax = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] StepV     = PWM_W'(STEP);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  logic [TickW-1:0] tick_cnt_q;
  logic             tick_q;
  state_e           state_q;
  logic [NLED-1:0]  shadow_q;
  logic             led_hb_q;
  logic [MissW-1:0] miss_q;
  logic             stall_q;
  logic [FadeW-1:0] fade_cnt_q;
  logic             fade_stb;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] bright_q [NLED];
  logic [PWM_W-1:0] bright_d [NLED];
  logic [NLED-1:0]  led_q;

  // EN can only rise while a request is pending, so it also drops with the async reset.
  assign cv_if.count_value_en = (state_q == StReq) & cv_if.count_value_rdy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_q     <= (tick_cnt_q == TickLast);
      tick_cnt_q <= (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      led_hb_q <= 1'b0;
      miss_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (tick_q) state_q <= StReq;
        StReq: begin
          if (cv_if.count_value_rdy) begin
            shadow_q <= cv_if.count_value_rv;
            led_hb_q <= ~led_hb_q;
            miss_q   <= '0;
            state_q  <= tick_q ? StReq : StIdle;
          end else if (tick_q) begin
            // Ticks are not queued; a tick landing on a pending request counts as a miss.
            if (miss_q != MissMax) miss_q <= miss_q + 1'b1;
            if (miss_q >= MissLast) stall_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fade_stb = (fade_cnt_q == FadeLast);

  function automatic logic [PWM_W-1:0] fade_step(logic [PWM_W-1:0] cur, logic up);
    logic [PWM_W-1:0] tgt;
    tgt = up ? BrightMax : '0;
    if (cur < tgt) return ((tgt - cur) <= StepV) ? tgt : cur + StepV;
    if (cur > tgt) return ((cur - tgt) <= StepV) ? tgt : cur - StepV;
    return cur;
  endfunction

  always_comb begin
    for (int i = 0; i < NLED; i++) begin
      bright_d[i] = fade_stb ? fade_step(bright_q[i], shadow_q[i]) : bright_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fade_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      led_q      <= '0;
      for (int i = 0; i < NLED; i++) bright_q[i] <= '0;
    end else begin
      fade_cnt_q <= fade_stb ? '0 : fade_cnt_q + 1'b1;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
      for (int i = 0; i < NLED; i++) begin
        bright_q[i] <= bright_d[i];
        led_q[i]    <= (bright_q[i] == BrightMax) | (bright_q[i] > pwm_cnt_q);
      end
    end
  end

  assign tick_o   = tick_q;
  assign led_o    = led_q;
  assign led_hb_o = led_hb_q;
  assign stall_o  = stall_q;

endmodule

// File: tb/tb_count_led_driver.sv
// Directed bench for count_led_driver with small dividers; outputs sampled on the falling edge.
module tb_count_led_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick;
  logic [3:0] led;
  logic       led_hb;
  logic       stall;

  int vectors = 0;
  int miscompares = 0;

  count_led_driver_if #(.NLED(4)) cv_if ();

  count_led_driver #(
    .NLED         (4),
    .TICK_DIV     (8),
    .PWM_W        (4),
    .FADE_DIV     (2),
    .STEP         (1),
    .TIMEOUT_TICKS(4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .cv_if   (cv_if),
    .tick_o  (tick),
    .led_o   (led),
    .led_hb_o(led_hb),
    .stall_o (stall)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns on the falling edge inside the next tick cycle; a missing tick is a failure.
  task automatic wait_tick(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = tick;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: tick got 0 within 40 cycles, want 1", name);
    end
  endtask

  task automatic test_reset();
    cv_if.count_value_rdy = 1'b1;
    cv_if.count_value_rv  = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (cv_if.count_value_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_en: got %b want 0", cv_if.count_value_en);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({tick, led, led_hb, stall} !== 7'b0 || dut.shadow_q !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_outs: got tick=%b led=%b hb=%b stall=%b shadow=%h want all 0",
               tick, led, led_hb, stall, dut.shadow_q);
    end
    rst = 1'b0;
  endtask

  task automatic test_capture();
    logic hb0;
    cv_if.count_value_rv  = 4'b0101;
    cv_if.count_value_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      hb0 = led_hb;
      wait_tick("capture_tick");
      vectors++;
      if (cv_if.count_value_en !== 1'b0) begin
        miscompares++;
        $display("FAIL capture_en_t: got %b want 0", cv_if.count_value_en);
      end
      @(negedge clk);
      vectors++;
      if (cv_if.count_value_en !== 1'b1) begin
        miscompares++;
        $display("FAIL capture_en_t1: got %b want 1", cv_if.count_value_en);
      end
      @(negedge clk);
      vectors++;
      if (cv_if.count_value_en !== 1'b0 || dut.shadow_q !== 4'd5 || led_hb !== ~hb0) begin
        miscompares++;
        $display("FAIL capture_t2: got en=%b shadow=%0d hb=%b want en=0 shadow=5 hb=%b",
                 cv_if.count_value_en, dut.shadow_q, led_hb, ~hb0);
      end
    end
  endtask

  task automatic test_fade_up();
    logic [3:0] prev;
    logic [3:0] b;
    int ups = 0;
    int bad = 0;
    int off = 0;
    do_reset();
    cv_if.count_value_rv  = 4'b0101;
    cv_if.count_value_rdy = 1'b1;
    prev = 4'd0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      b = dut.bright_q[0];
      if (b != prev) begin
        if (b != prev + 4'd1) bad++;
        else ups++;
      end
      prev = b;
    end
    vectors++;
    if (ups != 15 || bad != 0 || prev !== 4'd15) begin
      miscompares++;
      $display("FAIL fade_ramp0: got ups=%0d bad=%0d final=%0d want 15/0/15", ups, bad, prev);
    end
    vectors++;
    if (dut.bright_q[1] !== 4'd0 || dut.bright_q[2] !== 4'd15 || dut.bright_q[3] !== 4'd0) begin
      miscompares++;
      $display("FAIL fade_others: got %0d %0d %0d want 0 15 0",
               dut.bright_q[1], dut.bright_q[2], dut.bright_q[3]);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (led !== 4'b0101) off++;
    end
    vectors++;
    if (off != 0) begin
      miscompares++;
      $display("FAIL fade_led_const: got %0d cycles off 0101 want 0", off);
    end
  endtask

  task automatic test_miss_recover();
    int ticks = 0;
    int en_hi = 0;
    wait_tick("recover_sync");
    repeat (2) @(negedge clk);
    cv_if.count_value_rdy = 1'b0;
    // First tick opens the request; the other three find it unserved.
    for (int i = 0; i < 60 && ticks < 4; i++) begin
      @(negedge clk);
      if (cv_if.count_value_en) en_hi++;
      if (tick) ticks++;
    end
    @(negedge clk);
    vectors++;
    if (ticks != 4 || en_hi != 0 || dut.miss_q !== 3'd3 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL recover_wait: got ticks=%0d en_hi=%0d miss=%0d stall=%b want 4/0/3/0",
               ticks, en_hi, dut.miss_q, stall);
    end
    cv_if.count_value_rdy = 1'b1;
    #1;
    vectors++;
    if (cv_if.count_value_en !== 1'b1) begin
      miscompares++;
      $display("FAIL recover_en: got %b want 1", cv_if.count_value_en);
    end
    @(negedge clk);
    vectors++;
    if (cv_if.count_value_en !== 1'b0 || dut.miss_q !== 3'd0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL recover_after: got en=%b miss=%0d stall=%b want 0/0/0",
               cv_if.count_value_en, dut.miss_q, stall);
    end
  endtask

  task automatic test_stall();
    int ticks = 0;
    cv_if.count_value_rdy = 1'b0;
    for (int i = 0; i < 60 && ticks < 4; i++) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_early: got %b want 0 after 3 missed ticks", stall);
    end
    wait_tick("stall_tick");
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_set: got %b want 1 after 4 missed ticks", stall);
    end
    cv_if.count_value_rdy = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_sticky: got %b want 1", stall);
    end
    do_reset();
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_clear: got %b want 0", stall);
    end
  endtask

  task automatic test_reverse();
    logic [3:0] prev;
    logic [3:0] b;
    logic [3:0] peak;
    bit found = 0;
    int downs = 0;
    int bad = 0;
    do_reset();
    cv_if.count_value_rv  = 4'b0001;
    cv_if.count_value_rdy = 1'b1;
    for (int i = 0; i < 40 && !led_hb; i++) @(negedge clk);
    // Hold the next request pending so the flip lands exactly when we release RDY.
    cv_if.count_value_rdy = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = (dut.bright_q[0] == 4'd7);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reverse_reach7: got bright0=%0d want 7", dut.bright_q[0]);
    end
    cv_if.count_value_rv  = 4'b0000;
    cv_if.count_value_rdy = 1'b1;
    prev = dut.bright_q[0];
    peak = prev;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      b = dut.bright_q[0];
      if (b != prev) begin
        if (b == prev - 4'd1) downs++;
        else if (!(downs == 0 && b == prev + 4'd1 && prev == 4'd7)) bad++;
      end
      if (b > peak) peak = b;
      prev = b;
    end
    vectors++;
    if (!(peak == 4'd7 || peak == 4'd8) || bad != 0 || downs != int'(peak) || prev !== 4'd0) begin
      miscompares++;
      $display("FAIL reverse_ramp: got peak=%0d downs=%0d bad=%0d final=%0d want peak 7|8, downs=peak, 0, 0",
               peak, downs, bad, prev);
    end
    vectors++;
    if (led[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reverse_led: got %b want 0", led[0]);
    end
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    cv_if.count_value_rv  = 4'b1010;
    cv_if.count_value_rdy = 1'b0;
    wait_tick("midreq_tick");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 cv_if.count_value_rdy = 1'b1;
    #1;
    vectors++;
    if (cv_if.count_value_en !== 1'b0) begin
      miscompares++;
      $display("FAIL midreq_en: got %b want 0", cv_if.count_value_en);
    end
    @(negedge clk);
    vectors++;
    if ({tick, led, led_hb, stall} !== 7'b0 || dut.shadow_q !== 4'd0) begin
      miscompares++;
      $display("FAIL midreq_outs: got tick=%b led=%b hb=%b stall=%b shadow=%h want all 0",
               tick, led, led_hb, stall, dut.shadow_q);
    end
    rst = 1'b0;
    wait_tick("midreq_restart");
    vectors++;
    if (cv_if.count_value_en !== 1'b0) begin
      miscompares++;
      $display("FAIL midreq_en_t: got %b want 0", cv_if.count_value_en);
    end
    @(negedge clk);
    vectors++;
    if (cv_if.count_value_en !== 1'b1) begin
      miscompares++;
      $display("FAIL midreq_en_t1: got %b want 1", cv_if.count_value_en);
    end
    @(negedge clk);
    vectors++;
    if (dut.shadow_q !== 4'b1010 || led_hb !== 1'b1) begin
      miscompares++;
      $display("FAIL midreq_capture: got shadow=%b hb=%b want 1010/1", dut.shadow_q, led_hb);
    end
  endtask

  initial begin
    cv_if.count_value_rdy = 1'b0;
    cv_if.count_value_rv  = 4'b0000;
    test_reset();
    test_capture();
    test_fade_up();
    test_miss_recover();
    test_stall();
    test_reverse();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
